// File: rtl/alu_mc_if.sv
// rtl/alu_mc_if.sv - request/response bundle between the EX datapath and alu_mc
interface alu_mc_if #(
  parameter int WIDTH = 32
) ();
  logic             start_i;
  logic [3:0]       ctrl_i;
  logic [WIDTH-1:0] src1_i;
  logic [WIDTH-1:0] src2_i;
  logic [WIDTH-1:0] result_o;
  logic             zero_o;
  logic             valid_o;
  logic             busy_o;

  modport slave (
    input  start_i, ctrl_i, src1_i, src2_i,
    output result_o, zero_o, valid_o, busy_o
  );

  modport master (
    output start_i, ctrl_i, src1_i, src2_i,
    input  result_o, zero_o, valid_o, busy_o
  );
endinterface

// File: rtl/alu_mc.sv
// rtl/alu_mc.sv - multi-cycle ALU with iterative shift-add multiplier
module alu_mc #(
  parameter int WIDTH = 32
) (
  input  logic   clk_i,
  input  logic   rst_i,
  alu_mc_if.slave bus
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  localparam logic [3:0] OP_AND = 4'd0;
  localparam logic [3:0] OP_OR  = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_MUL = 4'd3;
  localparam logic [3:0] OP_SUB = 4'd6;
  localparam logic [3:0] OP_SLT = 4'd7;

  // DONE is the single cycle in which the multiply result is presented;
  // the last MUL edge already loads result/valid so latency is WIDTH+1.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplr_q, mplr_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [WIDTH-1:0] alu_out;
  logic [WIDTH-1:0] acc_step;

  // Single-cycle ops; unused codes deliberately produce zero.
  always_comb begin
    alu_out = '0;
    case (bus.ctrl_i)
      OP_AND:  alu_out = bus.src1_i & bus.src2_i;
      OP_OR:   alu_out = bus.src1_i | bus.src2_i;
      OP_ADD:  alu_out = bus.src1_i + bus.src2_i;
      OP_SUB:  alu_out = bus.src1_i - bus.src2_i;
      OP_SLT:  alu_out = {{(WIDTH-1){1'b0}}, ($signed(bus.src1_i) < $signed(bus.src2_i))};
      default: alu_out = '0;
    endcase
  end

  // One shift-add step: accumulate the shifted multiplicand when the current multiplier bit is set.
  always_comb begin
    acc_step = acc_q;
    if (mplr_q[0]) begin
      acc_step = acc_q + mcand_q;
    end
  end

  // Next-state and datapath updates for the IDLE/MUL/DONE controller.
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    valid_d  = 1'b0;
    busy_d   = busy_q;
    mcand_d  = mcand_q;
    mplr_d   = mplr_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start_i) begin
          if (bus.ctrl_i == OP_MUL) begin
            mcand_d = bus.src1_i;
            mplr_d  = bus.src2_i;
            acc_d   = '0;
            cnt_d   = '0;
            busy_d  = 1'b1;
            state_d = S_MUL;
          end else begin
            result_d = alu_out;
            valid_d  = 1'b1;
          end
        end
      end
      S_MUL: begin
        acc_d   = acc_step;
        mcand_d = mcand_q << 1;
        mplr_d  = mplr_q >> 1;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) begin
          result_d = acc_step;
          valid_d  = 1'b1;
          busy_d   = 1'b0;
          cnt_d    = '0;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset aborts any multiply in flight.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      mcand_q  <= '0;
      mplr_q   <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      mcand_q  <= mcand_d;
      mplr_q   <= mplr_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.result_o = result_q;
  assign bus.zero_o   = (result_q == '0);
  assign bus.valid_o  = valid_q;
  assign bus.busy_o   = busy_q;

endmodule

// File: tb/tb_alu_mc.sv
// tb/tb_alu_mc.sv - self-checking bench for alu_mc
module tb_alu_mc;
  localparam int WIDTH = 32;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  alu_mc_if #(.WIDTH(WIDTH)) bus ();
  alu_mc #(.WIDTH(WIDTH)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  typedef struct {
    string       name;
    logic [3:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] model(input logic [3:0] c, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0] p;
    case (c)
      4'd0: return a & b;
      4'd1: return a | b;
      4'd2: return a + b;
      4'd3: begin p = 64'(a) * 64'(b); return p[31:0]; end
      4'd6: return a - b;
      4'd7: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  task automatic single_op(input string name, input logic [3:0] c, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp);
    bus.start_i = 1'b1;
    bus.ctrl_i  = c;
    bus.src1_i  = a;
    bus.src2_i  = b;
    tick();
    bus.start_i = 1'b0;
    chk({name, " valid"}, 32'(bus.valid_o), 32'd1);
    chk({name, " result"}, bus.result_o, exp);
    chk({name, " zero"}, 32'(bus.zero_o), 32'(exp == 32'd0));
    chk({name, " busy"}, 32'(bus.busy_o), 32'd0);
    tick();
    chk({name, " valid drop"}, 32'(bus.valid_o), 32'd0);
    chk({name, " hold"}, bus.result_o, exp);
  endtask

  task automatic mul_op(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input bit poke);
    int n;
    logic [31:0] prev;
    prev = bus.result_o;
    bus.start_i = 1'b1;
    bus.ctrl_i  = 4'd3;
    bus.src1_i  = a;
    bus.src2_i  = b;
    tick();
    bus.start_i = 1'b0;
    n = 0;
    while (bus.busy_o === 1'b1 && n < 100) begin
      chk({name, " no early valid"}, 32'(bus.valid_o), 32'd0);
      chk({name, " result held"}, bus.result_o, prev);
      if (poke && (n % 5 == 2)) begin
        bus.start_i = 1'b1;
        bus.ctrl_i  = 4'd2;
        bus.src1_i  = 32'd5;
        bus.src2_i  = 32'd6;
      end else begin
        bus.start_i = 1'b0;
      end
      tick();
      n++;
    end
    bus.start_i = 1'b0;
    chk({name, " busy cycles"}, 32'(n), 32'(WIDTH));
    chk({name, " valid"}, 32'(bus.valid_o), 32'd1);
    chk({name, " result"}, bus.result_o, exp);
    chk({name, " zero"}, 32'(bus.zero_o), 32'(exp == 32'd0));
    if (poke) begin
      bus.start_i = 1'b1;
      bus.ctrl_i  = 4'd2;
      bus.src1_i  = 32'd5;
      bus.src2_i  = 32'd6;
    end
    tick();
    bus.start_i = 1'b0;
    chk({name, " valid drop"}, 32'(bus.valid_o), 32'd0);
    chk({name, " hold"}, bus.result_o, exp);
    chk({name, " busy low"}, 32'(bus.busy_o), 32'd0);
  endtask

  initial begin
    logic [3:0]  ops [9];
    logic [3:0]  c;
    logic [31:0] a;
    logic [31:0] b;

    ops = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd6, 4'd7, 4'd4, 4'd5, 4'd12};

    vecs[0] = '{"and",      4'd0,  32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200};
    vecs[1] = '{"or",       4'd1,  32'hF000_0001, 32'h0000_0F00, 32'hF000_0F01};
    vecs[2] = '{"add wrap", 4'd2,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000};
    vecs[3] = '{"sub neg",  4'd6,  32'd3,         32'd5,         32'hFFFF_FFFE};
    vecs[4] = '{"slt pos",  4'd7,  32'd5,         32'hFFFF_FFFD, 32'd0};
    vecs[5] = '{"slt neg",  4'd7,  32'hFFFF_FFFB, 32'd3,         32'd1};
    vecs[6] = '{"slt min",  4'd7,  32'h8000_0000, 32'h7FFF_FFFF, 32'd1};
    vecs[7] = '{"code4",    4'd4,  32'd9,         32'd9,         32'd0};
    vecs[8] = '{"code5",    4'd5,  32'd3,         32'd4,         32'd0};
    vecs[9] = '{"code15",   4'd15, 32'hFFFF_FFFF, 32'd1,         32'd0};

    rst         = 1'b0;
    bus.start_i = 1'b0;
    bus.ctrl_i  = 4'd0;
    bus.src1_i  = '0;
    bus.src2_i  = '0;
    tick();
    tick();
    chk("reset result", bus.result_o, 32'd0);
    chk("reset zero", 32'(bus.zero_o), 32'd1);
    chk("reset valid", 32'(bus.valid_o), 32'd0);
    chk("reset busy", 32'(bus.busy_o), 32'd0);
    rst = 1'b1;
    tick();

    // back-to-back single-cycle ops with start held high
    bus.start_i = 1'b1;
    bus.ctrl_i = 4'd2; bus.src1_i = 32'd7; bus.src2_i = 32'd9;
    tick();
    chk("b2b add valid", 32'(bus.valid_o), 32'd1);
    chk("b2b add result", bus.result_o, 32'd16);
    chk("b2b add zero", 32'(bus.zero_o), 32'd0);
    bus.ctrl_i = 4'd6; bus.src1_i = 32'd5; bus.src2_i = 32'd5;
    tick();
    chk("b2b sub valid", 32'(bus.valid_o), 32'd1);
    chk("b2b sub result", bus.result_o, 32'd0);
    chk("b2b sub zero", 32'(bus.zero_o), 32'd1);
    bus.ctrl_i = 4'd7; bus.src1_i = 32'hFFFF_FFFF; bus.src2_i = 32'd1;
    tick();
    chk("b2b slt valid", 32'(bus.valid_o), 32'd1);
    chk("b2b slt result", bus.result_o, 32'd1);
    bus.start_i = 1'b0;
    tick();
    chk("b2b valid drop", 32'(bus.valid_o), 32'd0);

    for (int i = 0; i < 10; i++) begin
      single_op(vecs[i].name, vecs[i].ctrl, vecs[i].a, vecs[i].b, vecs[i].exp);
    end

    mul_op("mul small", 32'h0000_1234, 32'h0000_0010, 32'h0001_2340, 1'b0);
    mul_op("mul ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1);
    mul_op("mul zero", 32'hDEAD_BEEF, 32'h0, 32'h0, 1'b0);

    // reset in the middle of a multiply
    bus.start_i = 1'b1;
    bus.ctrl_i = 4'd3; bus.src1_i = 32'h0000_1234; bus.src2_i = 32'h0000_0010;
    tick();
    bus.start_i = 1'b0;
    repeat (9) tick();
    chk("abort busy before", 32'(bus.busy_o), 32'd1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("abort busy", 32'(bus.busy_o), 32'd0);
    chk("abort result", bus.result_o, 32'd0);
    chk("abort valid", 32'(bus.valid_o), 32'd0);
    chk("abort zero", 32'(bus.zero_o), 32'd1);
    for (int i = 0; i < 40; i++) begin
      tick();
      chk("abort no valid", 32'(bus.valid_o), 32'd0);
    end
    single_op("post abort add", 4'd2, 32'd1, 32'd1, 32'd2);

    // randomized ops against the reference model
    for (int i = 0; i < 30; i++) begin
      c = ops[$urandom_range(0, 8)];
      a = $urandom();
      b = $urandom();
      if ($urandom_range(0, 3) == 0) b = b & 32'hFF;
      if (c == 4'd3) mul_op("rand mul", a, b, model(c, a, b), bit'($urandom_range(0, 1)));
      else single_op("rand op", c, a, b, model(c, a, b));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
